axi_sram_slave: RTL and testbench

- Single-ported AXI3 slave responder: the far end of the CPU's AXI master port.
- Backs a word-addressed register-array memory and serves single-beat reads and writes.
- Used as the simulation and FPGA memory model behind the CPU top.
- Independent read and write channel FSMs with one outstanding transaction per direction and a configurable read latency.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/sram_bytewe.sv | 52 +++++
 rtl/axi_sram_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 constants and the channel FSM state types used by the SRAM slave
// and the CPU-side bridge.
package axi_pkg;

    localparam int         AXI_ID_W        = 4;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/sram_bytewe.sv
// Word-addressed register-array memory: one registered read port and one
// byte-enabled write port. A read and a write to the same word on one edge return the old word.
module sram_bytewe #(
    parameter int ADDR_W    = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       wdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] rd_word;
    logic [31:0] rd_data_d, rd_data_q;

    // The array itself is never reset; only its contents at elaboration differ.
    if (INIT_ZERO != 0) begin : g_zero
        logic [31:0] mem [DEPTH] = '{default: '0};
        always_ff @(posedge clk) begin
            for (int b = 0; b < 4; b++)
                if (we && wstrb[b]) mem[wr_addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        assign rd_word = mem[rd_addr];
    end else begin : g_raw
        logic [31:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            for (int b = 0; b < 4; b++)
                if (we && wstrb[b]) mem[wr_addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        assign rd_word = mem[rd_addr];
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = rd_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave in front of a byte-writable SRAM: independent read and
// write channel FSMs, one outstanding transaction each, configurable read latency.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    // ---------------- read channel ----------------
    rd_state_e             rd_state_d, rd_state_q;
    logic [3:0]            cnt_d, cnt_q;
    logic                  arready_d, arready_q;
    logic                  rvalid_d, rvalid_q;
    logic [AXI_ID_W-1:0]   rid_d, rid_q;
    logic [1:0]            rresp_d, rresp_q;
    logic                  rd_en;

    always_comb begin
        rd_state_d = rd_state_q;
        cnt_d      = cnt_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rid_d      = rid_q;
        rresp_d    = rresp_q;
        rd_en      = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rd_en     = 1'b1;
                    arready_d = 1'b0;
                    rid_d     = arid;
                    rresp_d   = (arlen != 8'd0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    cnt_d     = LAT_LOAD;
                    if (LAT_LOAD == 4'd0) begin
                        rvalid_d   = 1'b1;
                        rd_state_d = R_RESP;
                    end else begin
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rvalid_d   = 1'b1;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            cnt_q      <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            cnt_q      <= cnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
            rresp_q    <= rresp_d;
        end
    end

    // ---------------- write channel ----------------
    wr_state_e             wr_state_d, wr_state_q;
    logic                  aw_got_d, aw_got_q, w_got_d, w_got_q;
    logic                  awready_d, awready_q, wready_d, wready_q;
    logic [AXI_ID_W-1:0]   awid_d, awid_q;
    logic [ADDR_W-1:0]     awidx_d, awidx_q;
    logic                  aw_err_d, aw_err_q;
    logic [31:0]           wdata_d, wdata_q;
    logic [3:0]            wstrb_d, wstrb_q;
    logic                  bvalid_d, bvalid_q;
    logic [AXI_ID_W-1:0]   bid_d, bid_q;
    logic [1:0]            bresp_d, bresp_q;
    logic                  mem_we;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        awid_d     = awid_q;
        awidx_d    = awidx_q;
        aw_err_d   = aw_err_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                // Commit one cycle after the later of the two halves lands.
                if (aw_got_q && w_got_q) begin
                    mem_we     = !aw_err_q;
                    bvalid_d   = 1'b1;
                    bid_d      = awid_q;
                    bresp_d    = aw_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    wr_state_d = W_RESP;
                end else begin
                    if (awvalid && awready_q) begin
                        aw_got_d  = 1'b1;
                        awready_d = 1'b0;
                        awid_d    = awid;
                        awidx_d   = awaddr[ADDR_W+1:2];
                        aw_err_d  = (awlen != 8'd0);
                    end
                    if (wvalid && wready_q) begin
                        w_got_d  = 1'b1;
                        wready_d = 1'b0;
                        wdata_d  = wdata;
                        wstrb_d  = wstrb;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d   = 1'b0;
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            awid_q     <= '0;
            awidx_q    <= '0;
            aw_err_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= AXI_RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            awid_q     <= awid_d;
            awidx_q    <= awidx_d;
            aw_err_q   <= aw_err_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
        end
    end

    sram_bytewe #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_mem (
        .clk     (aclk),
        .rst_n   (aresetn),
        .rd_en   (rd_en),
        .rd_addr (araddr[ADDR_W+1:2]),
        .rd_data (rdata),
        .we      (mem_we),
        .wr_addr (awidx_q),
        .wstrb   (wstrb_q),
        .wdata   (wdata_q)
    );

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rlast   = 1'b1;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;

    logic unused_ok;
    assign unused_ok = ^{arsize, wid, wlast, araddr[31:ADDR_W+2], araddr[1:0],
                         awaddr[31:ADDR_W+2], awaddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (RD_LAT=3): hand-computed write/read vectors,
// strobes, errors, wrap, backpressure, read/write collision and mid-read reset.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b1;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_W(10), .RD_LAT(3), .INIT_ZERO(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait for B, accept it, return id/resp.
    task automatic wait_b(output logic [3:0] b_id, output logic [1:0] b_resp);
        bit seen = 0;
        bready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            if (bvalid) begin seen = 1; b_id = bid; b_resp = bresp; end
        end
        chk("bvalid_seen", 32'(seen), 32'd1);
        if (!seen) begin b_id = 'x; b_resp = 'x; end
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // W is presented w_lead cycles before AW (0 = together).
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] id,
                             input logic [7:0] len, input int w_lead,
                             output logic [3:0] b_id, output logic [1:0] b_resp);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        @(posedge aclk); #1;
        awaddr = addr; awid = id; awlen = len; wdata = data; wstrb = strb;
        wvalid = 1'b1; awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge aclk);
            if (w_done && !aw_done) chk("wready_drop", 32'(wready), 32'd0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge aclk); #1;
            cyc++;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin wvalid = 1'b0; w_done = 1; end
            if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
        end
        chk("wr_handshakes", 32'(aw_done && w_done), 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        wait_b(b_id, b_resp);
    endtask

    // Call #1 after the AR handshake edge. lat counts cycles to first rvalid;
    // rready is held low for `hold` further cycles while R must stay stable.
    task automatic wait_r(input int hold, output logic [31:0] d, output logic [3:0] id,
                          output logic [1:0] resp, output logic last, output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge aclk);
            lat++;
            if (rvalid) begin seen = 1; d = rdata; id = rid; resp = rresp; last = rlast; end
        end
        chk("rvalid_seen", 32'(seen), 32'd1);
        if (!seen) begin d = 'x; id = 'x; resp = 'x; last = 'x; end
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            chk("hold_rvalid", 32'(rvalid), 32'd1);
            chk("hold_rdata", rdata, d);
            chk("hold_rid", 32'(rid), 32'(id));
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        chk("rvalid_clear", 32'(rvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input int hold, output logic [31:0] d, output logic [3:0] r_id,
                            output logic [1:0] resp, output logic last, output int lat);
        bit done = 0, hs;
        @(posedge aclk); #1;
        araddr = addr; arid = id; arlen = len; arvalid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge aclk);
            hs = arvalid && arready;
            @(posedge aclk); #1;
            if (hs) begin arvalid = 1'b0; done = 1; end
        end
        chk("ar_handshake", 32'(done), 32'd1);
        arvalid = 1'b0;
        wait_r(hold, d, r_id, resp, last, lat);
    endtask

    logic [3:0]  b_id, r_id;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] d;
    logic        last;
    int          lat;

    initial begin
        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_wready",  32'(wready),  32'd1);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        chk("rst_ids",     32'({rid, bid, rresp, bresp}), 32'd0);
        @(negedge aclk); aresetn = 1'b1;

        // Write then read, latency 3
        axi_write(32'h1C0, 32'hDEADBEEF, 4'hF, 4'd1, 8'd0, 0, b_id, b_resp);
        chk("wr1_bid", 32'(b_id), 32'd1);
        chk("wr1_bresp", 32'(b_resp), 32'd0);
        axi_read(32'h1C0, 4'd3, 8'd0, 0, d, r_id, r_resp, last, lat);
        chk("rd1_data", d, 32'hDEADBEEF);
        chk("rd1_rid", 32'(r_id), 32'd3);
        chk("rd1_rresp", 32'(r_resp), 32'd0);
        chk("rd1_rlast", 32'(last), 32'd1);
        chk("rd1_latency", 32'(lat), 32'd3);

        // W three cycles before AW
        axi_write(32'h40, 32'h11223344, 4'hF, 4'd7, 8'd0, 3, b_id, b_resp);
        chk("wlead_bid", 32'(b_id), 32'd7);
        chk("wlead_bresp", 32'(b_resp), 32'd0);
        axi_read(32'h40, 4'd2, 8'd0, 0, d, r_id, r_resp, last, lat);
        chk("wlead_data", d, 32'h11223344);

        // Partial strobe 0101
        axi_write(32'h80, 32'hAAAAAAAA, 4'hF, 4'd0, 8'd0, 0, b_id, b_resp);
        axi_write(32'h80, 32'h55667788, 4'b0101, 4'd0, 8'd0, 0, b_id, b_resp);
        axi_read(32'h80, 4'd0, 8'd0, 0, d, r_id, r_resp, last, lat);
        chk("strb_data", d, 32'hAA66AA88);

        // wstrb=0 leaves data, OKAY
        axi_write(32'h40, 32'hFFFFFFFF, 4'h0, 4'd4, 8'd0, 0, b_id, b_resp);
        chk("strb0_bresp", 32'(b_resp), 32'd0);
        axi_read(32'h43, 4'd0, 8'd0, 0, d, r_id, r_resp, last, lat);
        chk("strb0_data", d, 32'h11223344);

        // Address wrap with 5 cycles of backpressure
        axi_write(32'h0, 32'hCAFEF00D, 4'hF, 4'd0, 8'd0, 0, b_id, b_resp);
        axi_read(32'h1000, 4'd9, 8'd0, 5, d, r_id, r_resp, last, lat);
        chk("wrap_data", d, 32'hCAFEF00D);
        chk("wrap_rid", 32'(r_id), 32'd9);

        // Error responses
        axi_read(32'h1C0, 4'd6, 8'd3, 0, d, r_id, r_resp, last, lat);
        chk("arlen_rresp", 32'(r_resp), 32'd2);
        chk("arlen_rlast", 32'(last), 32'd1);
        axi_write(32'h1C0, 32'h12345678, 4'hF, 4'd5, 8'd1, 0, b_id, b_resp);
        chk("awlen_bresp", 32'(b_resp), 32'd2);
        chk("awlen_bid", 32'(b_id), 32'd5);
        axi_read(32'h1C0, 4'd0, 8'd0, 0, d, r_id, r_resp, last, lat);
        chk("awlen_nowrite", d, 32'hDEADBEEF);

        // Collision: AR sampled on the commit edge of a write to the same word
        axi_write(32'h20, 32'h01010101, 4'hF, 4'd0, 8'd0, 0, b_id, b_resp);
        @(posedge aclk); #1;
        awaddr = 32'h20; awid = 4'd2; awlen = 8'd0; wdata = 32'hFEEDFACE; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h20; arid = 4'd5; arlen = 8'd0; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        chk("coll_bvalid", 32'(bvalid), 32'd1);
        wait_r(0, d, r_id, r_resp, last, lat);
        chk("coll_old", d, 32'h01010101);
        wait_b(b_id, b_resp);
        chk("coll_bid", 32'(b_id), 32'd2);
        axi_read(32'h20, 4'd0, 8'd0, 0, d, r_id, r_resp, last, lat);
        chk("coll_new", d, 32'hFEEDFACE);

        // Reset while the read waits out its latency
        @(posedge aclk); #1;
        araddr = 32'h1C0; arid = 4'd8; arlen = 8'd0; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        chk("rwait_arready", 32'(arready), 32'd0);
        chk("rwait_rvalid", 32'(rvalid), 32'd0);
        #2 aresetn = 1'b0;
        #1;
        chk("mrst_rvalid", 32'(rvalid), 32'd0);
        chk("mrst_arready", 32'(arready), 32'd1);
        chk("mrst_rdata", rdata, 32'd0);
        @(negedge aclk); aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        chk("mrst_no_stale", 32'(rvalid), 32'd0);
        axi_read(32'h1C0, 4'd1, 8'd0, 0, d, r_id, r_resp, last, lat);
        chk("mrst_mem_kept", d, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
